// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch stage with a first-word-fall-through {pc, instr} queue to decode
// Optional FETCH_REDIRECT_EN adds redirect_valid/redirect_pc (flush queue, reload PC).
module fetch_queue #(
    parameter int                  PC_WIDTH    = 12,
    parameter int                  INSTR_WIDTH = 32,
    parameter int                  QUEUE_DEPTH = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter int                  PC_STEP     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         imem_req,
    output logic [PC_WIDTH-1:0]          imem_addr,
    input  logic [INSTR_WIDTH-1:0]       imem_rdata,
    output logic                         dec_valid,
    input  logic                         dec_ready,
    output logic [PC_WIDTH-1:0]          dec_pc,
    output logic [INSTR_WIDTH-1:0]       dec_instr,
    output logic [$clog2(QUEUE_DEPTH):0] occupancy
`ifdef FETCH_REDIRECT_EN
    ,
    input  logic                         redirect_valid,
    input  logic [PC_WIDTH-1:0]          redirect_pc
`endif
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;

    logic [PC_WIDTH-1:0]    pc;
    logic [PC_WIDTH-1:0]    pc_q;
    logic                   inflight;
    logic [PW-1:0]          rd_ptr;
    logic [PW-1:0]          wr_ptr;
    logic [CW-1:0]          count;
    logic [CW:0]            pending;
    logic                   flush;
    logic                   push;
    logic                   pop;

    logic [PC_WIDTH-1:0]    mem_pc    [QUEUE_DEPTH];
    logic [INSTR_WIDTH-1:0] mem_instr [QUEUE_DEPTH];

`ifdef FETCH_REDIRECT_EN
    assign flush = redirect_valid;
`else
    assign flush = 1'b0;
`endif

    // Credit counts entries held plus the one response still in flight;
    // a pop in the same cycle is deliberately not credited.
    assign pending  = {1'b0, count} + (CW+1)'(inflight);
    assign imem_req = !rst && !flush && (pending < (CW+1)'(QUEUE_DEPTH));
    assign imem_addr = pc;

    assign dec_valid = (count != '0);
    assign dec_pc    = mem_pc[rd_ptr];
    assign dec_instr = mem_instr[rd_ptr];
    assign occupancy = count;

    assign push = inflight && !flush;
    assign pop  = dec_valid && dec_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            pc_q     <= RESET_PC;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (flush) begin
`ifdef FETCH_REDIRECT_EN
            pc       <= redirect_pc;
`endif
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                pc   <= pc + PC_WIDTH'(PC_STEP);
                pc_q <= pc;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: count gates visibility of every entry.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_pc[wr_ptr]    <= pc_q;
            mem_instr[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue (scoreboarded PC/instr ordering)
// Build with FETCH_REDIRECT_EN defined to also exercise the redirect path.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req, imem_req2;
    logic [11:0] imem_addr, imem_addr2;
    logic [31:0] imem_rdata = '0, imem_rdata2 = '0;
    logic        dec_valid, dec_valid2;
    logic        dec_ready = 1'b0;
    logic        dec_ready2 = 1'b1;
    logic [11:0] dec_pc, dec_pc2;
    logic [31:0] dec_instr, dec_instr2;
    logic [2:0]  occupancy, occupancy2;
`ifdef FETCH_REDIRECT_EN
    logic        redirect_valid = 1'b0;
    logic [11:0] redirect_pc = '0;
    logic        redirect_valid2 = 1'b0;
    logic [11:0] redirect_pc2 = '0;
`endif

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];
    logic [11:0] exp2_q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] f(input logic [11:0] a);
        return {~a, 8'h5A, a};
    endfunction

    // Synchronous instruction memory: data one cycle after the address.
    always @(posedge clk) begin
        imem_rdata  <= f(imem_addr);
        imem_rdata2 <= f(imem_addr2);
    end

    fetch_queue dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_pc(dec_pc), .dec_instr(dec_instr), .occupancy(occupancy)
`ifdef FETCH_REDIRECT_EN
        , .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`endif
    );

    fetch_queue #(.RESET_PC(12'hFF8)) dut2 (
        .clk(clk), .rst(rst),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
        .dec_valid(dec_valid2), .dec_ready(dec_ready2),
        .dec_pc(dec_pc2), .dec_instr(dec_instr2), .occupancy(occupancy2)
`ifdef FETCH_REDIRECT_EN
        , .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2)
`endif
    );

    // Overflow must never happen under the credit rule.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (occupancy > 3'd4) begin
                errors++;
                $display("FAIL overflow occupancy=%0d max=4", occupancy);
            end
        end
    end

    task automatic apply_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dec_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b want=0", imem_req); end
        checks++;
        if (dec_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", dec_valid); end
        checks++;
        if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ got=%0d want=0", occupancy); end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (dec_valid !== 1'b0 || occupancy !== 3'd0) begin
            errors++; $display("FAIL post_reset valid=%b occ=%0d want 0/0", dec_valid, occupancy);
        end
    endtask

    task automatic test_latency_order();
        logic [11:0] e;
        dec_ready = 1'b0;
        apply_reset();
        dec_ready = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(12'(i * 4));
        @(negedge clk);
        checks++;
        if (dec_valid !== 1'b0) begin errors++; $display("FAIL latency_t1 got=%b want=0", dec_valid); end
        @(negedge clk);
        checks++;
        if (dec_valid !== 1'b1) begin errors++; $display("FAIL latency_t2 got=%b want=1", dec_valid); end
        for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
            if (dec_valid && dec_ready) begin
                e = exp_q.pop_front();
                checks++;
                if (dec_pc !== e || dec_instr !== f(e)) begin
                    errors++; $display("FAIL order pc=%h instr=%h want pc=%h instr=%h", dec_pc, dec_instr, e, f(e));
                end
            end
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL order_timeout left=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_fill_drain();
        logic [11:0] e;
        dec_ready = 1'b0;
        apply_reset();
        for (int cyc = 0; cyc < 20 && occupancy != 3'd4; cyc++) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (occupancy !== 3'd4 || imem_req !== 1'b0 || dec_pc !== 12'h000) begin
                errors++; $display("FAIL full occ=%0d req=%b pc=%h want 4/0/000", occupancy, imem_req, dec_pc);
            end
        end
        exp_q.delete();
        for (int i = 0; i < 5; i++) exp_q.push_back(12'(i * 4));
        dec_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            e = exp_q.pop_front();
            checks++;
            if (dec_valid !== 1'b1 || dec_pc !== e || dec_instr !== f(e)) begin
                errors++; $display("FAIL drain valid=%b pc=%h want 1/%h", dec_valid, dec_pc, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_wrap();
        logic [11:0] e;
        exp2_q.delete();
        exp2_q.push_back(12'hFF8);
        exp2_q.push_back(12'hFFC);
        exp2_q.push_back(12'h000);
        exp2_q.push_back(12'h004);
        apply_reset();
        for (int cyc = 0; cyc < 20 && exp2_q.size() > 0; cyc++) begin
            if (dec_valid2 && dec_ready2) begin
                e = exp2_q.pop_front();
                checks++;
                if (dec_pc2 !== e || dec_instr2 !== f(e)) begin
                    errors++; $display("FAIL wrap pc=%h instr=%h want pc=%h", dec_pc2, dec_instr2, e);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (exp2_q.size() != 0) begin errors++; $display("FAIL wrap_timeout left=%0d want=0", exp2_q.size()); end
    endtask

    task automatic test_steady();
        logic [11:0] e;
        dec_ready = 1'b1;
        apply_reset();
        exp_q.delete();
        for (int i = 0; i < 10; i++) exp_q.push_back(12'(i * 4));
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            e = exp_q.pop_front();
            checks++;
            if (occupancy !== 3'd1 || dec_valid !== 1'b1 || dec_pc !== e) begin
                errors++; $display("FAIL steady occ=%0d valid=%b pc=%h want 1/1/%h", occupancy, dec_valid, dec_pc, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] e;
        dec_ready = 1'b0;
        apply_reset();
        for (int cyc = 0; cyc < 20 && occupancy != 3'd2; cyc++) @(negedge clk);
        checks++;
        if (occupancy !== 3'd2) begin errors++; $display("FAIL midrst_fill occ=%0d want=2", occupancy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (dec_valid !== 1'b0 || occupancy !== 3'd0) begin
            errors++; $display("FAIL midrst_flush valid=%b occ=%0d want 0/0", dec_valid, occupancy);
        end
        @(negedge clk);
        checks++;
        if (dec_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale valid=%b want=0", dec_valid); end
        exp_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back(12'(i * 4));
        dec_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && exp_q.size() > 0; cyc++) begin
            if (dec_valid && dec_ready) begin
                e = exp_q.pop_front();
                checks++;
                if (dec_pc !== e || dec_instr !== f(e)) begin
                    errors++; $display("FAIL midrst_order pc=%h want=%h", dec_pc, e);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL midrst_timeout left=%0d want=0", exp_q.size()); end
    endtask

`ifdef FETCH_REDIRECT_EN
    task automatic test_redirect();
        logic [11:0] e;
        dec_ready = 1'b0;
        apply_reset();
        for (int cyc = 0; cyc < 20 && occupancy != 3'd3; cyc++) @(negedge clk);
        checks++;
        if (occupancy !== 3'd3) begin errors++; $display("FAIL redir_fill occ=%0d want=3", occupancy); end
        redirect_valid = 1'b1;
        redirect_pc = 12'h100;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_req got=%b want=0", imem_req); end
        @(negedge clk);
        redirect_valid = 1'b0;
        dec_ready = 1'b1;
        checks++;
        if (dec_valid !== 1'b0 || occupancy !== 3'd0) begin
            errors++; $display("FAIL redir_flush valid=%b occ=%0d want 0/0", dec_valid, occupancy);
        end
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(12'h100 + 12'(i * 4));
        @(negedge clk);
        checks++;
        if (dec_valid !== 1'b0) begin errors++; $display("FAIL redir_t2 valid=%b want=0", dec_valid); end
        @(negedge clk);
        checks++;
        if (dec_valid !== 1'b1) begin errors++; $display("FAIL redir_t3 valid=%b want=1", dec_valid); end
        for (int cyc = 0; cyc < 20 && exp_q.size() > 0; cyc++) begin
            if (dec_valid && dec_ready) begin
                e = exp_q.pop_front();
                checks++;
                if (dec_pc !== e || dec_instr !== f(e)) begin
                    errors++; $display("FAIL redir_order pc=%h want=%h", dec_pc, e);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL redir_timeout left=%0d want=0", exp_q.size()); end
    endtask
`endif

    initial begin
        test_reset();
        test_latency_order();
        test_fill_drain();
        test_wrap();
        test_steady();
        test_reset_mid();
`ifdef FETCH_REDIRECT_EN
        test_redirect();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

endmodule
